stage_3_renorm_pipe: RTL

- Registered, handshaked successor to the combinational stage-3 renormaliser of the AV1 arithmetic-encoder pipeline.
- Receives the post-update low/range from stage 2.
- Renormalises range to MSB-aligned and shifts low accordingly.
- Holds the bit counter internally and emits 0–2 pre-carry words per symbol to the carry-resolution/bitstream stage.
- Width generic; valid/ready on both sides.

---
 rtl/stage_3_renorm_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/stage_3_renorm_pipe.sv
// AV1 entropy-encoder stage 3: MSB-aligns range, shifts low and emits 0-2 pre-carry words per symbol.
// Define STAGE3_SKID_EN to replace the single output register with a 2-entry skid buffer.
module stage_3_renorm_pipe #(
   parameter int RANGE_WIDTH = 16,
   parameter int LOW_WIDTH   = 24,
   parameter int D_SIZE      = 5,
   parameter int CNT_INIT    = -9
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [RANGE_WIDTH-1:0] in_range,
   input  logic [LOW_WIDTH-1:0]   in_low,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [RANGE_WIDTH-1:0] out_range,
   output logic [LOW_WIDTH-1:0]   out_low,
   output logic [D_SIZE-1:0]      out_cnt,
   output logic [1:0]             out_word_cnt,
   output logic [RANGE_WIDTH-1:0] out_word_0,
   output logic [RANGE_WIDTH-1:0] out_word_1
);
   localparam int RES_W = 3*RANGE_WIDTH + LOW_WIDTH + D_SIZE + 2;
   localparam logic [RES_W-1:0] RESET_RES = {{(RANGE_WIDTH+LOW_WIDTH){1'b0}}, D_SIZE'(CNT_INIT),
                                             {(2+2*RANGE_WIDTH){1'b0}}};

   // Leading-zero count of range; a zero range is left unshifted.
   function automatic int norm_shift(input logic [RANGE_WIDTH-1:0] r);
      int sh;
      sh = 0;
      for (int i = 0; i < RANGE_WIDTH; i++)
         if (r[i]) sh = RANGE_WIDTH - 1 - i;
      return sh;
   endfunction

   function automatic logic [LOW_WIDTH-1:0] low_mask(input int c);
      return ~({LOW_WIDTH{1'b1}} << c);
   endfunction

   logic signed [D_SIZE-1:0] cnt_q;
   logic [D_SIZE-1:0]        nxt_cnt;
   logic [RES_W-1:0]         nxt_res;
   logic [RES_W-1:0]         head;
   logic                     accept;

   // Stage p0: combinational renormalisation and word extraction
   always_comb begin
      int c0, d, s, c;
      logic [LOW_WIDTH-1:0]   low_v;
      logic [RANGE_WIDTH-1:0] w0, w1;
      logic [1:0]             wc;
      c0    = start ? CNT_INIT : int'(cnt_q);
      d     = norm_shift(in_range);
      s     = c0 + d;
      c     = 0;
      low_v = in_low;
      w0    = '0;
      w1    = '0;
      wc    = 2'd0;
      if (s >= 0) begin
         c = c0 + RANGE_WIDTH;
         if (s >= 8) begin
            w0    = RANGE_WIDTH'(low_v >> c);
            low_v = low_v & low_mask(c);
            c     = c - 8;
            w1    = RANGE_WIDTH'(low_v >> c);
            wc    = 2'd2;
         end else begin
            w0 = RANGE_WIDTH'(low_v >> c);
            wc = 2'd1;
         end
         low_v = low_v & low_mask(c);
         s     = c + d - (RANGE_WIDTH + 8);
      end
      nxt_cnt = D_SIZE'(s);
      nxt_res = {RANGE_WIDTH'(in_range << d), LOW_WIDTH'(low_v << d), nxt_cnt, wc, w0, w1};
   end

   assign accept = in_valid && in_ready;

   // The counter loop closes in a single cycle; start alone just reloads it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    cnt_q <= D_SIZE'(CNT_INIT);
      else if (accept) cnt_q <= nxt_cnt;
      else if (start)  cnt_q <= D_SIZE'(CNT_INIT);
   end

`ifdef STAGE3_SKID_EN
   // Stage p1: two-entry skid buffer; in_ready is registered from the next fill level
   logic [RES_W-1:0] buf_p1 [2];
   logic [1:0]       fill, fill_nxt;
   logic             rd_ptr, wr_ptr, rdy_q, pop;

   assign pop = (fill != 2'd0) && out_ready;

   always_comb begin
      fill_nxt = fill;
      if (accept && !pop)      fill_nxt = fill + 2'd1;
      else if (!accept && pop) fill_nxt = fill - 2'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill      <= 2'd0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         rdy_q     <= 1'b1;
         buf_p1[0] <= RESET_RES;
         buf_p1[1] <= RESET_RES;
      end else begin
         fill  <= fill_nxt;
         rdy_q <= (fill_nxt != 2'd2);
         if (accept) begin
            buf_p1[wr_ptr] <= nxt_res;
            wr_ptr         <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (fill != 2'd0);
   assign head      = buf_p1[rd_ptr];
`else
   // Stage p1: single output register
   logic             vld_p1;
   logic [RES_W-1:0] res_p1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1 <= 1'b0;
         res_p1 <= RESET_RES;
      end else if (accept) begin
         vld_p1 <= 1'b1;
         res_p1 <= nxt_res;
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign in_ready  = !vld_p1 || out_ready;
   assign out_valid = vld_p1;
   assign head      = res_p1;
`endif

   assign {out_range, out_low, out_cnt, out_word_cnt, out_word_0, out_word_1} = head;

endmodule
